// File: rtl/mem_responder.sv
// mem_responder: word-organised, byte-addressed RAM behind a valid/ready
// request channel with a one-cycle response pulse and programmable wait states.
//
// Handshake: a request is taken on a rising edge where req_valid & req_ready
// are both high; req_ready is high only in IDLE. The response is a single
// resp_valid pulse that cannot be back-pressured; resp_rdata/resp_err are only
// meaningful while resp_valid is high and hold their value otherwise.
module mem_responder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  fsm_state
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  logic [1:0]            state;
  logic [3:0]            wait_cnt;
  logic                  lat_wr;
  logic [1:0]            lat_size;
  logic [1:0]            lat_off;
  logic [ADDR_WIDTH-1:0] lat_idx;
  logic [31:0]           lat_wdata;
  logic                  lat_err;
  logic [31:0]           rd_word;
  logic [31:0]           mem [DEPTH];

  logic        accept;
  logic        addr_err;
  logic [3:0]  byte_en;
  logic [31:0] wr_lanes;
  logic [31:0] rd_shifted;
  logic [31:0] rd_sel;

  assign req_ready = (state == ST_IDLE);
  assign accept    = req_valid & req_ready;
  assign fsm_state = state;

  // Classify the incoming request: misaligned, reserved size or beyond the array.
  always_comb begin
    addr_err = 1'b0;
    if (req_size == 2'b11) addr_err = 1'b1;
    if ((req_size == 2'b00) && (req_addr[1:0] != 2'b00)) addr_err = 1'b1;
    if ((req_size == 2'b01) && req_addr[0]) addr_err = 1'b1;
    if (|req_addr[31:ADDR_WIDTH+2]) addr_err = 1'b1;
  end

  // Lane enables, write-data placement and read-data extraction for the latched request.
  always_comb begin
    byte_en    = 4'b0000;
    rd_sel     = 32'd0;
    wr_lanes   = lat_wdata << {lat_off, 3'b000};
    rd_shifted = rd_word >> {lat_off, 3'b000};
    case (lat_size)
      2'b00: begin
        byte_en = 4'b1111;
        rd_sel  = rd_shifted;
      end
      2'b01: begin
        byte_en = lat_off[1] ? 4'b1100 : 4'b0011;
        rd_sel  = {16'd0, rd_shifted[15:0]};
      end
      2'b10: begin
        byte_en = 4'b0001 << lat_off;
        rd_sel  = {24'd0, rd_shifted[7:0]};
      end
      default: begin
        byte_en = 4'b0000;
        rd_sel  = 32'd0;
      end
    endcase
  end

  // Request sequencing: IDLE -> WAIT (optional) -> ACCESS -> RESP -> IDLE, response registered on leaving RESP.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      wait_cnt   <= 4'd0;
      lat_wr     <= 1'b0;
      lat_size   <= 2'b00;
      lat_off    <= 2'b00;
      lat_idx    <= '0;
      lat_wdata  <= 32'd0;
      lat_err    <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            lat_wr    <= req_wr;
            lat_size  <= req_size;
            lat_off   <= req_addr[1:0];
            lat_idx   <= req_addr[ADDR_WIDTH+1:2];
            lat_wdata <= req_wdata;
            lat_err   <= addr_err;
            wait_cnt  <= 4'd0;
            state     <= (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            state <= ST_ACCESS;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        ST_ACCESS: begin
          state <= ST_RESP;
        end
        default: begin
          state      <= ST_IDLE;
          resp_valid <= 1'b1;
          resp_err   <= lat_err;
          resp_rdata <= (lat_wr || lat_err) ? 32'd0 : rd_sel;
        end
      endcase
    end
  end

  // Storage array: not reset; touched only at the ACCESS edge of a good request.
  always_ff @(posedge clock) begin
    if (state == ST_ACCESS) begin
      rd_word <= mem[lat_idx];
      if (lat_wr && !lat_err) begin
        for (int k = 0; k < 4; k++) begin
          if (byte_en[k]) mem[lat_idx][8*k +: 8] <= wr_lanes[8*k +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances with WAIT_CYCLES 0, 1 and 3.
// Instance 1 carries the functional scenarios; 0 and 2 carry the throughput scenario.
module tb_mem_responder;

  logic        clock;
  logic        reset;
  logic        rv   [3];
  logic        rw   [3];
  logic [1:0]  rs   [3];
  logic [31:0] ra   [3];
  logic [31:0] rwd  [3];
  logic        rdy  [3];
  logic        resp_v [3];
  logic [31:0] rdat [3];
  logic        rerr [3];
  logic [1:0]  st   [3];

  int checks;
  int failures;

  mem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) u_w0 (
    .clock(clock), .reset(reset), .req_valid(rv[0]), .req_ready(rdy[0]), .req_wr(rw[0]),
    .req_size(rs[0]), .req_addr(ra[0]), .req_wdata(rwd[0]), .resp_valid(resp_v[0]),
    .resp_rdata(rdat[0]), .resp_err(rerr[0]), .fsm_state(st[0]));

  mem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(1)) u_w1 (
    .clock(clock), .reset(reset), .req_valid(rv[1]), .req_ready(rdy[1]), .req_wr(rw[1]),
    .req_size(rs[1]), .req_addr(ra[1]), .req_wdata(rwd[1]), .resp_valid(resp_v[1]),
    .resp_rdata(rdat[1]), .resp_err(rerr[1]), .fsm_state(st[1]));

  mem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(3)) u_w3 (
    .clock(clock), .reset(reset), .req_valid(rv[2]), .req_ready(rdy[2]), .req_wr(rw[2]),
    .req_size(rs[2]), .req_addr(ra[2]), .req_wdata(rwd[2]), .resp_valid(resp_v[2]),
    .resp_rdata(rdat[2]), .resp_err(rerr[2]), .fsm_state(st[2]));

  // Clock: 10 ns period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Issue one request on instance idx, report response data, latency (edges after accept) and pulse width.
  task automatic do_req(input int idx, input logic wr, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata_o, output logic err_o,
                        output int lat, output int width);
    int guard;
    guard   = 0;
    lat     = -1;
    width   = 0;
    rdata_o = 32'hxxxx_xxxx;
    err_o   = 1'bx;
    while (!rdy[idx] && guard < 50) begin
      @(posedge clock); #1;
      guard++;
    end
    rv[idx] = 1'b1; rw[idx] = wr; rs[idx] = size; ra[idx] = addr; rwd[idx] = wdata;
    @(posedge clock); #1;
    rv[idx] = 1'b0; rw[idx] = 1'b0; rs[idx] = 2'b00; ra[idx] = 32'd0; rwd[idx] = 32'd0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clock); #1;
      if (resp_v[idx]) begin
        lat     = k;
        rdata_o = rdat[idx];
        err_o   = rerr[idx];
        break;
      end
    end
    if (lat > 0) begin
      width = 1;
      for (int k = 0; k < 5; k++) begin
        @(posedge clock); #1;
        if (resp_v[idx]) width++;
        else break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rv[i] = 1'b0; rw[i] = 1'b0; rs[i] = 2'b00; ra[i] = 32'd0; rwd[i] = 32'd0;
    end
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({rdy[1], resp_v[1], rerr[1], st[1]} !== 5'b1_0_0_00 || rdat[1] !== 32'd0) begin
      failures++;
      $display("FAIL reset_state: ready=%b valid=%b err=%b state=%0d rdata=%h, want 1 0 0 0 00000000",
               rdy[1], resp_v[1], rerr[1], st[1], rdat[1]);
    end
    reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_reset_abort();
    logic [31:0] d; logic e; int lat, w; int seen;
    do_req(1, 1'b1, 2'b00, 32'h10, 32'h0102_0304, d, e, lat, w);
    rv[1] = 1'b1; rw[1] = 1'b1; rs[1] = 2'b00; ra[1] = 32'h10; rwd[1] = 32'hDEAD_BEEF;
    @(posedge clock); #1;
    rv[1] = 1'b0; rw[1] = 1'b0; ra[1] = 32'd0; rwd[1] = 32'd0;
    checks++;
    if (st[1] !== 2'd1) begin
      failures++;
      $display("FAIL abort_in_wait: state=%0d want 1", st[1]);
    end
    reset = 1'b0;
    seen = 0;
    repeat (3) begin
      @(posedge clock); #1;
      if (resp_v[1]) seen++;
    end
    reset = 1'b1;
    checks++;
    if (rdy[1] !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_release: ready=%b want 1", rdy[1]);
    end
    repeat (5) begin
      @(posedge clock); #1;
      if (resp_v[1]) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL no_resp_after_abort: pulses=%0d want 0", seen);
    end
    do_req(1, 1'b0, 2'b00, 32'h10, 32'd0, d, e, lat, w);
    checks++;
    if (d !== 32'h0102_0304 || e !== 1'b0) begin
      failures++;
      $display("FAIL aborted_write_dropped: rdata=%h err=%b want 01020304 0", d, e);
    end
  endtask

  task automatic test_word_rw();
    logic [31:0] d; logic e; int lat, w;
    do_req(1, 1'b1, 2'b00, 32'h20, 32'h1122_3344, d, e, lat, w);
    checks++;
    if (lat != 3 || w != 1 || d !== 32'd0 || e !== 1'b0) begin
      failures++;
      $display("FAIL word_write: lat=%0d width=%0d rdata=%h err=%b want 3 1 00000000 0", lat, w, d, e);
    end
    do_req(1, 1'b0, 2'b00, 32'h20, 32'd0, d, e, lat, w);
    checks++;
    if (lat != 3 || w != 1 || d !== 32'h1122_3344 || e !== 1'b0) begin
      failures++;
      $display("FAIL word_read: lat=%0d width=%0d rdata=%h err=%b want 3 1 11223344 0", lat, w, d, e);
    end
  endtask

  task automatic test_lanes();
    logic [31:0] d; logic e; int lat, w;
    do_req(1, 1'b1, 2'b10, 32'h23, 32'hFFFF_FFAA, d, e, lat, w);
    do_req(1, 1'b1, 2'b01, 32'h20, 32'h1234_BEEF, d, e, lat, w);
    do_req(1, 1'b0, 2'b00, 32'h20, 32'd0, d, e, lat, w);
    checks++;
    if (d !== 32'hAA22_BEEF || e !== 1'b0) begin
      failures++;
      $display("FAIL lane_merge_word: rdata=%h err=%b want aa22beef 0", d, e);
    end
    do_req(1, 1'b0, 2'b10, 32'h23, 32'd0, d, e, lat, w);
    checks++;
    if (d !== 32'h0000_00AA) begin
      failures++;
      $display("FAIL byte_read_3: rdata=%h want 000000aa", d);
    end
    do_req(1, 1'b0, 2'b10, 32'h21, 32'd0, d, e, lat, w);
    checks++;
    if (d !== 32'h0000_00BE) begin
      failures++;
      $display("FAIL byte_read_1: rdata=%h want 000000be", d);
    end
    do_req(1, 1'b0, 2'b01, 32'h22, 32'd0, d, e, lat, w);
    checks++;
    if (d !== 32'h0000_AA22) begin
      failures++;
      $display("FAIL half_read_2: rdata=%h want 0000aa22", d);
    end
  endtask

  task automatic test_errors();
    logic [31:0] d; logic e; int lat, w;
    logic        ewr   [5];
    logic [1:0]  esize [5];
    logic [31:0] eaddr [5];
    ewr[0] = 1'b0; esize[0] = 2'b00; eaddr[0] = 32'h22;
    ewr[1] = 1'b1; esize[1] = 2'b01; eaddr[1] = 32'h21;
    ewr[2] = 1'b0; esize[2] = 2'b11; eaddr[2] = 32'h20;
    ewr[3] = 1'b0; esize[3] = 2'b00; eaddr[3] = 32'h400;
    ewr[4] = 1'b1; esize[4] = 2'b00; eaddr[4] = 32'h420;
    for (int i = 0; i < 5; i++) begin
      do_req(1, ewr[i], esize[i], eaddr[i], 32'h5555_5555, d, e, lat, w);
      checks++;
      if (e !== 1'b1 || d !== 32'd0 || lat != 3 || w != 1) begin
        failures++;
        $display("FAIL error_case_%0d: err=%b rdata=%h lat=%0d width=%0d want 1 00000000 3 1",
                 i, e, d, lat, w);
      end
    end
    do_req(1, 1'b0, 2'b00, 32'h20, 32'd0, d, e, lat, w);
    checks++;
    if (d !== 32'hAA22_BEEF || e !== 1'b0) begin
      failures++;
      $display("FAIL ram_untouched_by_errors: rdata=%h err=%b want aa22beef 0", d, e);
    end
  endtask

  // Hold req_valid high over four writes; accepts must be exactly 'period' edges apart.
  task automatic test_back_to_back(input int idx, input int period);
    int acc_edge [4];
    int n_acc, edge_n, pulses, guard, low_cycles;
    logic prev_ready;
    n_acc = 0; edge_n = 0; pulses = 0; guard = 0; low_cycles = 0;
    while (!rdy[idx] && guard < 50) begin
      @(posedge clock); #1;
      guard++;
    end
    rv[idx] = 1'b1; rw[idx] = 1'b1; rs[idx] = 2'b00; ra[idx] = 32'h0; rwd[idx] = 32'h100;
    prev_ready = rdy[idx];
    while (n_acc < 4 && edge_n < 100) begin
      @(posedge clock); #1;
      edge_n++;
      if (resp_v[idx]) pulses++;
      if (prev_ready) begin
        acc_edge[n_acc] = edge_n;
        n_acc++;
        ra[idx]  = 32'(n_acc * 4);
        rwd[idx] = 32'(32'h100 + n_acc);
        if (n_acc == 4) rv[idx] = 1'b0;
      end
      if (n_acc > 0 && n_acc < 4 && !rdy[idx]) low_cycles++;
      prev_ready = rdy[idx];
    end
    rv[idx] = 1'b0;
    repeat (12) begin
      @(posedge clock); #1;
      if (resp_v[idx]) pulses++;
    end
    checks++;
    if (n_acc != 4) begin
      failures++;
      $display("FAIL b2b_accepts_w%0d: accepts=%0d want 4", period - 3, n_acc);
    end else begin
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (acc_edge[i] - acc_edge[i-1] != period) begin
          failures++;
          $display("FAIL b2b_interval_w%0d_%0d: interval=%0d want %0d",
                   period - 3, i, acc_edge[i] - acc_edge[i-1], period);
        end
      end
      checks++;
      if (low_cycles != 3 * (period - 1)) begin
        failures++;
        $display("FAIL b2b_ready_low_w%0d: low_cycles=%0d want %0d", period - 3, low_cycles, 3 * (period - 1));
      end
    end
    checks++;
    if (pulses != 4) begin
      failures++;
      $display("FAIL b2b_pulses_w%0d: pulses=%0d want 4", period - 3, pulses);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_reset_abort();
    test_word_rw();
    test_lanes();
    test_errors();
    test_back_to_back(0, 3);
    test_back_to_back(2, 6);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
